// File: rtl/cook_sequencer.sv
// Microwave cooking controller: keypad time entry, BCD chain load/clear/enable,
// magnetron drive, pause/resume on door or stop, and the end-of-cook beeper.
module cook_sequencer #(
  parameter int unsigned BEEP_TICKS = 3
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        tick_1hz,
  input  logic        key_valid,
  input  logic [3:0]  key_data,
  input  logic        start,
  input  logic        stop,
  input  logic        door_closed,
  input  logic        timer_zero,
  output logic [15:0] load_data,
  output logic        timer_loadn,
  output logic        timer_clrn,
  output logic        timer_en,
  output logic        magnetron_on,
  output logic        beep,
  output logic [2:0]  state
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StEntry = 3'd1;
  localparam logic [2:0] StLoad  = 3'd2;
  localparam logic [2:0] StCook  = 3'd3;
  localparam logic [2:0] StPause = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  localparam int unsigned CntW = $clog2(BEEP_TICKS + 1);
  localparam logic [CntW-1:0] BeepLast = CntW'(BEEP_TICKS - 1);

  logic [2:0]      r_state;
  logic [15:0]     r_entry;
  logic [CntW-1:0] r_beep_cnt;
  logic            r_mag;
  logic            r_beep;
  logic            r_clrn;

  logic [2:0]      w_state_d;
  logic [15:0]     w_entry_d;
  logic [CntW-1:0] w_beep_cnt_d;
  logic            w_clr_pulse;
  logic            w_key_ok;

  assign w_key_ok = key_valid && (key_data <= 4'd9);

  always_comb begin
    w_state_d    = r_state;
    w_entry_d    = r_entry;
    w_beep_cnt_d = r_beep_cnt;
    w_clr_pulse  = 1'b0;
    case (r_state)
      StIdle: begin
        if (stop) begin
          w_entry_d = '0;
        end else if (w_key_ok) begin
          w_entry_d = {r_entry[11:0], key_data};
          w_state_d = StEntry;
        end
      end
      StEntry: begin
        if (stop) begin
          w_entry_d = '0;
          w_state_d = StIdle;
        end else if (start) begin
          // A start that cannot launch is consumed, so a same-cycle key is dropped.
          if (door_closed && (r_entry != 16'h0000)) begin
            w_state_d = StLoad;
          end
        end else if (w_key_ok) begin
          w_entry_d = {r_entry[11:0], key_data};
        end
      end
      StLoad: begin
        // The chain's zero flag is stale this cycle, so nothing else is sampled.
        w_state_d = StCook;
      end
      StCook: begin
        if (stop || !door_closed) begin
          w_state_d = StPause;
        end else if (timer_zero) begin
          w_state_d = StDone;
        end
      end
      StPause: begin
        if (stop) begin
          w_state_d   = StIdle;
          w_entry_d   = '0;
          w_clr_pulse = 1'b1;
        end else if (start && door_closed) begin
          w_state_d = StCook;
        end
      end
      StDone: begin
        if (stop || !door_closed || (tick_1hz && (r_beep_cnt == BeepLast))) begin
          w_state_d    = StIdle;
          w_entry_d    = '0;
          w_beep_cnt_d = '0;
          w_clr_pulse  = 1'b1;
        end else if (tick_1hz) begin
          w_beep_cnt_d = r_beep_cnt + CntW'(1);
        end
      end
      default: begin
        w_state_d    = StIdle;
        w_entry_d    = '0;
        w_beep_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= StIdle;
      r_entry    <= '0;
      r_beep_cnt <= '0;
      r_mag      <= 1'b0;
      r_beep     <= 1'b0;
      r_clrn     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_entry    <= w_entry_d;
      r_beep_cnt <= w_beep_cnt_d;
      // Decoded from the current registered state, hence one cycle behind it.
      r_mag      <= (r_state == StCook);
      r_beep     <= (r_state == StDone);
      r_clrn     <= ~w_clr_pulse;
    end
  end

  // Gating stop and zero here keeps the chain from stepping past 00:00.
  assign timer_en     = (r_state == StCook) && tick_1hz && door_closed && !stop && !timer_zero;
  assign timer_loadn  = (r_state != StLoad);
  assign timer_clrn   = r_clrn;
  assign load_data    = r_entry;
  assign magnetron_on = r_mag;
  assign beep         = r_beep;
  assign state        = r_state;

endmodule

// File: tb/tb_cook_sequencer.sv
// Bench for cook_sequencer: directed stimulus, a BCD chain model, and a queue-based
// monitor checking state transitions, load events and clear pulses.
module tb_cook_sequencer;

  logic        clk;
  logic        clr;
  logic        tick_1hz;
  logic        key_valid;
  logic [3:0]  key_data;
  logic        start;
  logic        stop;
  logic        door_closed;
  logic        timer_zero;
  logic [15:0] load_data;
  logic        timer_loadn;
  logic        timer_clrn;
  logic        timer_en;
  logic        magnetron_on;
  logic        beep;
  logic [2:0]  state;

  int n_err = 0;
  int n_chk = 0;
  int beep_ticks = 0;

  logic [2:0]  q_state[$];
  logic [15:0] q_load[$];
  logic [2:0]  q_clrn[$];
  logic        mon_en = 1'b0;
  logic [2:0]  prev_state;
  logic [15:0] chain;

  cook_sequencer #(.BEEP_TICKS(3)) dut (
    .clk          (clk),
    .clr          (clr),
    .tick_1hz     (tick_1hz),
    .key_valid    (key_valid),
    .key_data     (key_data),
    .start        (start),
    .stop         (stop),
    .door_closed  (door_closed),
    .timer_zero   (timer_zero),
    .load_data    (load_data),
    .timer_loadn  (timer_loadn),
    .timer_clrn   (timer_clrn),
    .timer_en     (timer_en),
    .magnetron_on (magnetron_on),
    .beep         (beep),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] m1, m0, s1, s0;
    {m1, m0, s1, s0} = v;
    if (s0 != 4'd0) s0 = s0 - 4'd1;
    else begin
      s0 = 4'd9;
      if (s1 != 4'd0) s1 = s1 - 4'd1;
      else begin
        s1 = 4'd5;
        if (m0 != 4'd0) m0 = m0 - 4'd1;
        else begin
          m0 = 4'd9;
          m1 = m1 - 4'd1;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  // Model of the external MM:SS down-counter chain.
  always_ff @(posedge clk) begin
    if (timer_clrn === 1'b0) chain <= 16'h0000;
    else if (timer_loadn === 1'b0) chain <= load_data;
    else if (timer_en === 1'b1) chain <= bcd_dec(chain);
  end
  assign timer_zero = (chain == 16'h0000);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_chk++;
    n_err++;
    $display("FAIL %s: got unexpected 0x%0h expected no event", name, act);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (state !== prev_state) begin
        if (q_state.size() == 0) unexpected("state_seq", {29'd0, state});
        else chk("state_seq", {29'd0, state}, {29'd0, q_state.pop_front()});
        prev_state = state;
      end
      if (timer_loadn !== 1'b1) begin
        if (q_load.size() == 0) unexpected("load_event", {16'd0, load_data});
        else chk("load_event", {16'd0, load_data}, {16'd0, q_load.pop_front()});
      end
      if (timer_clrn !== 1'b1 && !clr) begin
        if (q_clrn.size() == 0) unexpected("clrn_pulse", {29'd0, state});
        else chk("clrn_pulse", {29'd0, state}, {29'd0, q_clrn.pop_front()});
      end
      if (tick_1hz && beep) beep_ticks++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press_key(input logic [3:0] d);
    key_valid = 1'b1;
    key_data  = d;
    cyc();
    key_valid = 1'b0;
    key_data  = 4'd0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  initial begin
    clr = 1'b1; tick_1hz = 1'b0; key_valid = 1'b0; key_data = 4'd0;
    start = 1'b0; stop = 1'b0; door_closed = 1'b1;

    // Reset
    cyc(); cyc();
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_mag", {31'd0, magnetron_on}, 32'd0);
    chk("rst_beep", {31'd0, beep}, 32'd0);
    chk("rst_clrn_low", {31'd0, timer_clrn}, 32'd0);
    chk("rst_loadn", {31'd0, timer_loadn}, 32'd1);
    chk("rst_en", {31'd0, timer_en}, 32'd0);
    chk("rst_load_data", {16'd0, load_data}, 32'h0000);
    clr = 1'b0;
    cyc();
    chk("rst_clrn_high", {31'd0, timer_clrn}, 32'd1);
    prev_state = state;
    mon_en = 1'b1;

    // Entry 1,3,0 then load and cook
    q_state.push_back(3'd1);
    press_key(4'd1); press_key(4'd3); press_key(4'd0);
    chk("entry_0130", {16'd0, load_data}, 32'h0130);
    q_state.push_back(3'd2); q_state.push_back(3'd3); q_load.push_back(16'h0130);
    pulse_start();
    chk("load_loadn_low", {31'd0, timer_loadn}, 32'd0);
    cyc();
    chk("cook_loadn_high", {31'd0, timer_loadn}, 32'd1);
    chk("mag_lag", {31'd0, magnetron_on}, 32'd0);
    cyc();
    chk("mag_on", {31'd0, magnetron_on}, 32'd1);
    chk("chain_loaded", {16'd0, chain}, 32'h0130);

    // Stop in COOK pauses, second stop clears
    q_state.push_back(3'd4);
    pulse_stop();
    cyc();
    chk("pause_mag_off", {31'd0, magnetron_on}, 32'd0);
    q_state.push_back(3'd0); q_clrn.push_back(3'd0);
    pulse_stop();
    chk("stop2_clrn_low", {31'd0, timer_clrn}, 32'd0);
    chk("stop2_entry_clr", {16'd0, load_data}, 32'h0000);
    cyc();
    chk("stop2_clrn_high", {31'd0, timer_clrn}, 32'd1);
    chk("chain_cleared", {16'd0, chain}, 32'h0000);

    // Five digits, invalid key, empty start, stop beats start, door-open start
    q_state.push_back(3'd1);
    for (int i = 1; i <= 5; i++) press_key(i[3:0]);
    chk("entry_2345", {16'd0, load_data}, 32'h2345);
    press_key(4'd12);
    chk("key12_ignored", {16'd0, load_data}, 32'h2345);
    q_state.push_back(3'd0);
    pulse_stop();
    chk("entry_stop_clr", {16'd0, load_data}, 32'h0000);
    q_state.push_back(3'd1);
    press_key(4'd0);
    pulse_start();
    chk("start_zero_stay", {29'd0, state}, 32'd1);
    q_state.push_back(3'd0);
    stop = 1'b1; start = 1'b1;
    cyc();
    stop = 1'b0; start = 1'b0;
    chk("stop_beats_start", {29'd0, state}, 32'd0);
    q_state.push_back(3'd1);
    press_key(4'd2);
    door_closed = 1'b0;
    pulse_start();
    chk("start_door_open", {29'd0, state}, 32'd1);
    door_closed = 1'b1;

    // Cook 00:02, door opens with a tick, resume, run to completion
    q_state.push_back(3'd2); q_state.push_back(3'd3); q_load.push_back(16'h0002);
    pulse_start();
    cyc(); cyc();
    tick_1hz = 1'b1; #1;
    chk("en_tick", {31'd0, timer_en}, 32'd1);
    cyc();
    tick_1hz = 1'b0;
    door_closed = 1'b0; tick_1hz = 1'b1; #1;
    chk("en_door_open", {31'd0, timer_en}, 32'd0);
    q_state.push_back(3'd4);
    cyc();
    tick_1hz = 1'b0;
    chk("door_pause", {29'd0, state}, 32'd4);
    cyc();
    chk("door_mag_off", {31'd0, magnetron_on}, 32'd0);
    chk("chain_held", {16'd0, chain}, 32'h0001);
    door_closed = 1'b1;
    q_state.push_back(3'd3);
    pulse_start();
    cyc();
    tick_1hz = 1'b1; #1;
    chk("en_resume", {31'd0, timer_en}, 32'd1);
    cyc();
    tick_1hz = 1'b0;
    tick_1hz = 1'b1; #1;
    chk("en_at_zero", {31'd0, timer_en}, 32'd0);
    q_state.push_back(3'd5);
    cyc();
    tick_1hz = 1'b0;
    chk("chain_no_wrap", {16'd0, chain}, 32'h0000);
    cyc();
    chk("beep_on", {31'd0, beep}, 32'd1);
    for (int t = 0; t < 2; t++) begin
      tick_1hz = 1'b1;
      cyc();
      tick_1hz = 1'b0;
      cyc(); cyc();
    end
    chk("done_still", {29'd0, state}, 32'd5);
    chk("beep_still", {31'd0, beep}, 32'd1);
    q_state.push_back(3'd0); q_clrn.push_back(3'd0);
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
    chk("done_idle", {29'd0, state}, 32'd0);
    chk("done_clrn_low", {31'd0, timer_clrn}, 32'd0);
    cyc();
    chk("done_clrn_high", {31'd0, timer_clrn}, 32'd1);
    chk("beep_off", {31'd0, beep}, 32'd0);
    chk("beep_ticks", beep_ticks, 32'd3);

    // clr in the middle of cooking
    q_state.push_back(3'd1);
    press_key(4'd5);
    q_state.push_back(3'd2); q_state.push_back(3'd3); q_load.push_back(16'h0005);
    pulse_start();
    cyc(); cyc();
    chk("cook2_mag_on", {31'd0, magnetron_on}, 32'd1);
    q_state.push_back(3'd0); q_clrn.push_back(3'd0);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr_idle", {29'd0, state}, 32'd0);
    chk("clr_mag_off", {31'd0, magnetron_on}, 32'd0);
    chk("clr_clrn_low", {31'd0, timer_clrn}, 32'd0);
    cyc();
    chk("clr_clrn_high", {31'd0, timer_clrn}, 32'd1);
    chk("clr_chain", {16'd0, chain}, 32'h0000);
    cyc(); cyc();

    chk("q_state_empty", q_state.size(), 32'd0);
    chk("q_load_empty", q_load.size(), 32'd0);
    chk("q_clrn_empty", q_clrn.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cook_sequencer.md
Name: cook_sequencer

Overview:
- Top-level cooking controller for the microwave.
- Collects the MM:SS cook time from the keypad and loads it into the BCD down-counter chain (the cascaded mod-10/mod-6 digit counters).
- Gates the counter chain's count enable from the 1 Hz tick.
- Drives the magnetron and the end-of-cook beeper, and handles pause, resume and clear in response to the door and the stop key.

Parameters:
- BEEP_TICKS, 3, number of tick_1hz pulses that beep stays high in DONE (≥1).

Ports:
- clk  in  1  system clock.
- clr  in  1  synchronous, active-high reset.
- tick_1hz  in  1  one-cycle pulse, once per second.
- key_valid  in  1  one-cycle pulse; key_data is valid.
- key_data  in  4  keypad digit (0-9 valid, 10-15 ignored).
- start  in  1  start/resume key pulse.
- stop  in  1  stop/clear key pulse.
- door_closed  in  1  door switch; 1 = closed.
- timer_zero  in  1  counter chain reads 00:00 (registered by the chain).
- load_data  out  16  BCD M1,M0,S1,S0 to the counter chain data inputs; equals the entry register.
- timer_loadn  out  1  active-low parallel load to the chain.
- timer_clrn  out  1  active-low clear to the chain.
- timer_en  out  1  count enable to the least-significant digit.
- magnetron_on  out  1  heating element drive.
- beep  out  1  end-of-cook beeper.
- state  out  3  current state code, for display and debug.

Behaviour:
- Reset is synchronous: clk rises with clr=1.
- Values after reset:
  - state = IDLE, entry = 0, beep counter = 0.
  - magnetron_on = 0, beep = 0, timer_en = 0, timer_loadn = 1.
  - timer_clrn = 0 while clr is high; it returns to 1 on the first clock edge after clr drops.
- State encoding: IDLE=0, ENTRY=1, LOAD=2, COOK=3, PAUSE=4, DONE=5. Codes 6-7 return to IDLE on the next clock edge.
- Event priority, highest first: clr > stop > door open > timer_zero > start > key_valid.
- Key entry:
  - Applies in IDLE or ENTRY when key_valid=1 and key_data ≤ 9.
  - entry <= {entry[11:0], key_data}; the top digit is discarded and the next state is ENTRY.
  - Keys are ignored in all other states. Invalid key codes are ignored.
  - No range check is done on the seconds digits: 99 is loaded as-is, and the chain handles it.
- ENTRY:
  - start with door_closed=1 and entry≠0 -> LOAD.
  - start with entry==0 or door open -> stay in ENTRY.
  - stop -> IDLE, entry cleared.
- LOAD:
  - Lasts exactly 1 cycle, with timer_loadn=0 and load_data=entry. Then -> COOK unconditionally.
  - timer_zero is not sampled in LOAD, because the chain's zero flag is stale there.
- COOK:
  - magnetron_on=1.
  - timer_en = tick_1hz & door_closed & ~stop & ~timer_zero. This is combinational and prevents the chain from wrapping 0->9.
  - stop -> PAUSE.
  - door_closed=0 -> PAUSE.
  - timer_zero=1 -> DONE.
- PAUSE:
  - magnetron_on=0, timer_en=0; the counter value is held.
  - start with door_closed=1 -> COOK, with no reload.
  - stop -> IDLE, with timer_clrn=0 for 1 cycle and entry cleared.
- DONE:
  - magnetron_on=0 and beep=1.
  - Each tick_1hz increments the beep counter. When the count reaches BEEP_TICKS -> IDLE with beep=0.
  - stop or door open -> IDLE immediately.
  - On leaving DONE: entry cleared, timer_clrn=0 for 1 cycle, beep counter reset.
- timer_clrn pulse: 1 cycle low on every transition into IDLE from PAUSE or DONE.
- Registered outputs: magnetron_on and beep are decoded from the registered state, so they change 1 cycle after the state edge.
- Combinational outputs: timer_en and timer_loadn.
- clr mid-cook: the next edge forces IDLE, magnetron off, and the chain cleared.

Test Plan:
- Reset: assert clr for 2 cycles -> state=0, magnetron_on=0, timer_clrn=0 during clr and 1 after, timer_loadn=1, load_data=0x0000.
- Entry and load: keys 1,3,0 then start, door closed -> load_data=0x0130, timer_loadn low exactly 1 cycle, state 1->2->3, magnetron_on=1.
- Five-digit entry: keys 1,2,3,4,5 -> load_data=0x2345. Key 12 -> ignored. start with entry 0 -> remains ENTRY.
- Door open mid-cook: in COOK, open the door together with a tick_1hz pulse -> timer_en stays 0 that cycle, state=PAUSE, magnetron_on=0. Close the door then start -> COOK with no timer_loadn pulse.
- Completion: chain model reaches 00:00 (timer_zero=1), then a tick arrives -> timer_en=0, state=DONE, beep=1 for exactly 3 ticks, then IDLE with one timer_clrn low cycle.
- Stop handling: stop in COOK -> PAUSE. A second stop -> IDLE, entry=0, timer_clrn low 1 cycle. stop and start in the same ENTRY cycle -> IDLE (stop wins).
